io_kbd_rd: RTL

IO_KBD_RD -- requirements
Module: io_kbd_rd

---
 rtl/io_kbd_pkg.sv | 43 ++++
 rtl/io_kbd_fifo.sv | 65 ++++++
 rtl/io_kbd_rd.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard reader: register offsets,
// receive FSM encoding, status bit layout and FIFO entry width.
package io_kbd_pkg;

    localparam logic [1:0] OFF_STAT = 2'd0;
    localparam logic [1:0] OFF_DATA = 2'd1;
    localparam logic [1:0] OFF_PEEK = 2'd2;

    localparam int SB_NE   = 0;
    localparam int SB_FULL = 1;
    localparam int SB_OVF  = 2;
    localparam int SB_ERR  = 3;
    localparam int SB_CNT  = 4;

    localparam int ENTRY_W = 9;

    localparam logic [7:0] BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } kbd_state_e;

    function automatic logic [15:0] stat_word(
        input logic [3:0] cnt,
        input logic       err,
        input logic       ovf,
        input logic       full,
        input logic       ne
    );
        logic [15:0] w;
        w = 16'h0000;
        w[SB_CNT +: 4] = cnt;
        w[SB_ERR]      = err;
        w[SB_OVF]      = ovf;
        w[SB_FULL]     = full;
        w[SB_NE]       = ne;
        return w;
    endfunction

endpackage

// File: rtl/io_kbd_fifo.sv
// Synchronous scancode FIFO; push on full is accepted only alongside a pop.
// count saturates at 15 so a 16-deep FIFO still fits a 4-bit field.
import io_kbd_pkg::*;

module io_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = ENTRY_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty,
    output logic [3:0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_do_pop;
    logic w_do_push;
    logic [4:0] w_cnt5;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rp];
    assign w_cnt5    = 5'(r_cnt);
    assign o_count   = w_cnt5[4] ? 4'hF : w_cnt5[3:0];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_do_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_kbd_rd.sv
// PS/2 keyboard receiver with scancode FIFO and CPU I/O register decode.
// Optional IO_KBD_BREAK_FILTER_EN folds F0 prefixes into a brk flag.
import io_kbd_pkg::*;

module io_kbd_rd #(
    parameter logic [7:0] BASE        = 8'hF0,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic [7:0]  ioad,
    input  logic        ior,
    output logic [15:0] iordt,
    output logic        iosel,
    output logic        kbd_irq
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic [3:0] r_c_hist;
    logic r_c_flt;
    logic r_fall;
    logic [2:0] w_ones;
    logic w_flt_nxt;
    logic w_d;

    assign w_d    = r_d_s2;
    assign w_ones = 3'(r_c_hist[0]) + 3'(r_c_hist[1])
                  + 3'(r_c_hist[2]) + 3'(r_c_hist[3]);

    // 2-2 ties hold the previous level so glitches never make an edge
    always_comb begin
        w_flt_nxt = r_c_flt;
        if (w_ones >= 3'd3) begin
            w_flt_nxt = 1'b1;
        end else if (w_ones <= 3'd1) begin
            w_flt_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_c_s1   <= 1'b1;
            r_c_s2   <= 1'b1;
            r_d_s1   <= 1'b1;
            r_d_s2   <= 1'b1;
            r_c_hist <= 4'hF;
            r_c_flt  <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_c_s1   <= ps2c;
            r_c_s2   <= r_c_s1;
            r_d_s1   <= ps2d;
            r_d_s2   <= r_d_s1;
            r_c_hist <= {r_c_hist[2:0], r_c_s2};
            r_c_flt  <= w_flt_nxt;
            r_fall   <= r_c_flt & ~w_flt_nxt;
        end
    end

    kbd_state_e r_state, w_state_nxt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [TW-1:0] r_tcnt;
    logic w_shift_en, w_par_ld, w_done, w_ferr, w_tout;

    assign w_tout = (r_state != ST_IDLE) && !r_fall
                 && (r_tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_ld    = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        if (w_tout) begin
            w_state_nxt = ST_IDLE;
            w_ferr      = 1'b1;
        end else if (r_fall) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_d) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_par_ld    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_d && ^{r_shift, r_par}) begin
                        w_done = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_d, r_shift[7:1]};
            end
            if (w_par_ld) begin
                r_par <= w_d;
            end
            if (r_state == ST_IDLE || r_fall) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    logic w_push_nxt;
    logic [ENTRY_W-1:0] w_pdat_nxt;
    logic r_push;
    logic [ENTRY_W-1:0] r_pdat;

`ifdef IO_KBD_BREAK_FILTER_EN
    logic r_brk;

    assign w_push_nxt = w_done && (r_shift != BRK_CODE);
    assign w_pdat_nxt = {r_brk, r_shift};

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_brk <= 1'b0;
        end else if (w_ferr) begin
            r_brk <= 1'b0;
        end else if (w_done) begin
            r_brk <= (r_shift == BRK_CODE);
        end
    end
`else
    assign w_push_nxt = w_done;
    assign w_pdat_nxt = {1'b0, r_shift};
`endif

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_push <= 1'b0;
            r_pdat <= '0;
        end else begin
            r_push <= w_push_nxt;
            r_pdat <= w_pdat_nxt;
        end
    end

    logic [7:0] w_off;
    logic w_hit, w_stat_rd, w_data_rd, w_pop;
    logic w_full, w_empty;
    logic [3:0] w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [15:0] w_rdata;
    logic r_err, r_ovf;
    logic [15:0] r_iordt;
    logic r_iosel;

    assign w_off     = ioad - BASE;
    assign w_hit     = (w_off <= 8'(OFF_PEEK));
    assign w_stat_rd = ior && (w_off == 8'(OFF_STAT));
    assign w_data_rd = ior && (w_off == 8'(OFF_DATA));
    assign w_pop     = w_data_rd && !w_empty;

    io_kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk   (clk50),
        .i_rst   (reset),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_din   (r_pdat),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_rdata = 16'h0000;
        if (w_hit) begin
            if (w_off == 8'(OFF_STAT)) begin
                w_rdata = stat_word(w_count, r_err, r_ovf, w_full, ~w_empty);
            end else if (!w_empty) begin
                w_rdata = {7'h00, w_head};
            end
        end
    end

    // set wins over a same-cycle status-read clear
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_iordt <= 16'h0000;
            r_iosel <= 1'b0;
        end else begin
            r_err   <= (r_err & ~w_stat_rd) | w_ferr;
            r_ovf   <= (r_ovf & ~w_stat_rd) | (r_push & w_full & ~w_pop);
            r_iosel <= ior & w_hit;
            if (ior) begin
                r_iordt <= w_rdata;
            end
        end
    end

    assign iordt   = r_iordt;
    assign iosel   = r_iosel;
    assign kbd_irq = ~w_empty;

endmodule
